// File: rtl/button_conditioner.sv
// Conditions the three active-low game buttons into synchronized, debounced,
// active-high levels with one-cycle press/release strobes and a long-press flag.
//
// state        | meaning
// RELEASED     | stable released, waiting for the synchronized input to go high
// PRESS_PEND   | input high, counting consecutive high cycles
// PRESSED      | stable pressed, waiting for the synchronized input to go low
// RELEASE_PEND | input low, counting consecutive low cycles
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_n,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic [2:0] btn_release,
    output logic [2:0] btn_hold
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    // Synchronizer flops keep the raw active-low polarity so reset means released.
    logic [2:0]    meta_n;
    logic [2:0]    sync_n;
    logic [2:0]    s;
    state_t        state    [3];
    logic [DW-1:0] db_cnt   [3];
    logic [HW-1:0] hold_cnt [3];

    assign s = ~sync_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_n      <= '1;
            sync_n      <= '1;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_hold    <= '0;
            for (int i = 0; i < 3; i++) begin
                state[i]    <= RELEASED;
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            meta_n <= btn_n;
            sync_n <= meta_n;
            for (int i = 0; i < 3; i++) begin
                btn_press[i]   <= 1'b0;
                btn_release[i] <= 1'b0;

                if (!btn_level[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_MAX) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
                btn_hold[i] <= btn_level[i] && (hold_cnt[i] == HOLD_MAX);

                case (state[i])
                    RELEASED: begin
                        if (s[i]) begin
                            state[i]  <= PRESS_PEND;
                            db_cnt[i] <= DW'(1);
                        end
                    end
                    PRESS_PEND: begin
                        if (!s[i]) begin
                            state[i]  <= RELEASED;
                            db_cnt[i] <= '0;
                        end else if (db_cnt[i] == DB_LAST) begin
                            state[i]     <= PRESSED;
                            db_cnt[i]    <= '0;
                            btn_level[i] <= 1'b1;
                            btn_press[i] <= 1'b1;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!s[i]) begin
                            state[i]  <= RELEASE_PEND;
                            db_cnt[i] <= DW'(1);
                        end
                    end
                    RELEASE_PEND: begin
                        if (s[i]) begin
                            state[i]  <= PRESSED;
                            db_cnt[i] <= '0;
                        end else if (db_cnt[i] == DB_LAST) begin
                            state[i]       <= RELEASED;
                            db_cnt[i]      <= '0;
                            btn_level[i]   <= 1'b0;
                            btn_release[i] <= 1'b1;
                            // hold must drop on the same edge as the level
                            btn_hold[i]    <= 1'b0;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i]  <= RELEASED;
                        db_cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus,
// all compared cycle by cycle against a run-length reference model.
module tb_button_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 10;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn_n = 3'b111;
    logic [2:0] btn_level, btn_press, btn_release, btn_hold;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold)
    );

    always #5 clk = ~clk;

    // Reference model: the level flips once the synchronized input has
    // disagreed with it for DB consecutive clock edges; hold is set once the
    // level has stayed high for more than HOLD edges after it rose.
    logic [2:0] h1 = 3'b111, h2 = 3'b111, m_s;
    logic [2:0] m_level = '0, m_press = '0, m_release = '0, m_hold = '0;
    logic       m_prev;
    int         run  [3];
    int         high [3];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            h1 = 3'b111; h2 = 3'b111;
            m_level = '0; m_press = '0; m_release = '0; m_hold = '0;
            for (int i = 0; i < 3; i++) begin
                run[i]  = 0;
                high[i] = 0;
            end
        end else begin
            m_s = ~h2;
            h2  = h1;
            h1  = btn_n;
            for (int i = 0; i < 3; i++) begin
                m_prev       = m_level[i];
                m_press[i]   = 1'b0;
                m_release[i] = 1'b0;
                if (m_s[i] != m_level[i]) run[i] = run[i] + 1;
                else                      run[i] = 0;
                if (run[i] == DB) begin
                    m_level[i]   = ~m_level[i];
                    m_press[i]   = m_level[i];
                    m_release[i] = ~m_level[i];
                    run[i]       = 0;
                end
                if (m_level[i] && m_prev) begin
                    if (high[i] < 1000) high[i] = high[i] + 1;
                end else begin
                    high[i] = 0;
                end
                m_hold[i] = m_level[i] && m_prev && (high[i] >= HOLD + 1);
            end
        end
    end

    function automatic logic [11:0] obs();
        return {btn_level, btn_press, btn_release, btn_hold};
    endfunction

    function automatic logic [11:0] expv();
        return {m_level, m_press, m_release, m_hold};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_n = 3'b000;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (obs() !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%h expected=000", cyc, obs());
            end
        end
        btn_n = 3'b111;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_clean_press();
        int t0, tp, np, tr, nr;
        tp = -1; np = 0; tr = -1; nr = 0;
        btn_n[1] = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL clean_model cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
            if ({btn_level[2], btn_level[0], btn_press[2], btn_press[0]} !== 4'b0) begin
                n_fail++;
                $display("FAIL clean_other_bits cyc=%0d level=%b press=%b", cyc, btn_level, btn_press);
            end
            if (btn_press[1] === 1'b1) begin
                np++;
                if (tp < 0) tp = cyc;
            end
        end
        n_checks++;
        if (tp - t0 != 6 || np != 1) begin
            n_fail++;
            $display("FAIL clean_press_latency got=%0d count=%0d expected=6 count=1", tp - t0, np);
        end
        btn_n[1] = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL clean_rel_model cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
            if (btn_release[1] === 1'b1) begin
                nr++;
                if (tr < 0) tr = cyc;
            end
        end
        n_checks++;
        if (tr - t0 != 6 || nr != 1 || btn_level[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_release_latency got=%0d count=%0d level=%b expected=6 count=1 level=0",
                     tr - t0, nr, btn_level[1]);
        end
    endtask

    task automatic test_bounce();
        int seg_len [4] = '{3, 2, 3, 2};
        int t0, tp, np;
        tp = -1; np = 0;
        for (int g = 0; g < 4; g++) begin
            btn_n[0] = (g % 2 == 1);
            for (int k = 0; k < seg_len[g]; k++) begin
                tick();
                n_checks++;
                if (obs() !== 12'h000) begin
                    n_fail++;
                    $display("FAIL bounce_quiet cyc=%0d got=%h expected=000", cyc, obs());
                end
            end
        end
        btn_n[0] = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL bounce_model cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
            if (btn_press[0] === 1'b1) begin
                np++;
                if (tp < 0) tp = cyc;
            end
        end
        n_checks++;
        if (tp - t0 != 6 || np != 1) begin
            n_fail++;
            $display("FAIL bounce_press got=%0d count=%0d expected=6 count=1", tp - t0, np);
        end
        btn_n[0] = 1'b1;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_long_press();
        int tl, th, np, tf_level, tf_hold, t_rel;
        tl = -1; th = -1; np = 0; tf_level = -1; tf_hold = -1; t_rel = -1;
        btn_n[2] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL long_model cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
            if (btn_level[2] === 1'b1 && tl < 0) tl = cyc;
            if (btn_hold[2] === 1'b1 && th < 0) th = cyc;
            if (btn_press[2] === 1'b1 || btn_release[2] === 1'b1) np++;
        end
        n_checks++;
        if (th - tl != HOLD + 1 || np != 1 || btn_hold[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL long_hold_latency got=%0d strobes=%0d hold=%b expected=%0d strobes=1 hold=1",
                     th - tl, np, btn_hold[2], HOLD + 1);
        end
        btn_n[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL long_rel_model cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
            if (btn_level[2] === 1'b0 && tf_level < 0) tf_level = cyc;
            if (btn_hold[2] === 1'b0 && tf_hold < 0) tf_hold = cyc;
            if (btn_release[2] === 1'b1 && t_rel < 0) t_rel = cyc;
        end
        n_checks++;
        if (tf_level < 0 || tf_level != tf_hold || tf_level != t_rel) begin
            n_fail++;
            $display("FAIL long_release_align got level=%0d hold=%0d release=%0d expected all equal",
                     tf_level, tf_hold, t_rel);
        end
    endtask

    task automatic test_simultaneous();
        int t0, p0, p1;
        p0 = -1; p1 = -1;
        btn_n[1:0] = 2'b00;
        t0 = cyc;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL simul_model cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
            if (btn_press[0] === 1'b1 && p0 < 0) p0 = cyc;
            if (btn_press[1] === 1'b1 && p1 < 0) p1 = cyc;
        end
        n_checks++;
        if (p0 != p1 || p0 - t0 != 6) begin
            n_fail++;
            $display("FAIL simul_press got p0=%0d p1=%0d expected both %0d", p0 - t0, p1 - t0, 6);
        end
        btn_n[1:0] = 2'b11;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_reset_mid_press();
        int t0, tp, th, guard;
        tp = -1; th = -1; guard = 0;
        btn_n[1] = 1'b0;
        while (btn_level[1] !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (btn_level[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_level_timeout got=%b expected=1", btn_level[1]);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs() !== 12'h000) begin
                n_fail++;
                $display("FAIL midreset_clear cyc=%0d got=%h expected=000", cyc, obs());
            end
        end
        reset = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 25; k++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL midreset_model cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
            if (btn_press[1] === 1'b1 && tp < 0) tp = cyc;
            if (btn_hold[1] === 1'b1 && th < 0) th = cyc;
        end
        n_checks++;
        if (tp - t0 != 6 || th - tp != HOLD + 1) begin
            n_fail++;
            $display("FAIL midreset_repress got press=%0d hold=%0d expected press=6 hold=%0d",
                     tp - t0, th - tp, HOLD + 1);
        end
        btn_n[1] = 1'b1;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 5) == 0) btn_n[i] = ~btn_n[i];
            reset = ($urandom_range(0, 99) == 0);
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got=%h expected=%h", cyc, obs(), expv());
            end
            if ((btn_press & btn_release) !== 3'b000) begin
                n_fail++;
                $display("FAIL random_strobe_overlap cyc=%0d press=%b release=%b", cyc, btn_press, btn_release);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input stage for the reflex-timer game. Takes the three raw active-low push buttons (ready, fire, game-reset) and turns them into synchronized, debounced, active-high levels plus one-cycle press/release strobes and a long-press flag. Its outputs drive the game FSM directly, which then needs no polarity inversion or edge detection of its own. Channels are fully independent.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); legal range ≥ 2.
- HOLD_CYCLES, default 100_000_000: cycles a debounced press must persist before btn_hold asserts; legal range ≥ 1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high; sampled on the rising edge of clk.
- btn_n, input, 3: raw asynchronous buttons, active-low; bit0 = ready, bit1 = fire, bit2 = game reset.
- btn_level, output, 3: debounced button state, 1 = pressed.
- btn_press, output, 3: one-cycle strobe on the cycle btn_level rises.
- btn_release, output, 3: one-cycle strobe on the cycle btn_level falls.
- btn_hold, output, 3: 1 while pressed for ≥ HOLD_CYCLES; clears together with btn_level.

## Operation

Per channel:
- **Synchronizer.** Two-flop synchronizer on btn_n[i], inverted to active-high `s[i]`. Both flops reset to the released value.
- **Debounce FSM.** States: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND. Counter width is $clog2(DEBOUNCE_CYCLES).
  - RELEASED: if s=1, go to PRESS_PEND with count=1.
  - PRESS_PEND: if s=0, return to RELEASED with count=0. If s=1 and count==DEBOUNCE_CYCLES-1, go to PRESSED, set btn_level=1, pulse btn_press. Otherwise count+1.
  - PRESSED and RELEASE_PEND: symmetric, on s=0, with btn_release pulsed on entry to RELEASED.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles returns the FSM to its stable state with count cleared. The glitch produces no output change.
- **Hold counter.**
  - Width $clog2(HOLD_CYCLES+1).
  - Cleared while btn_level=0.
  - Increments each cycle while btn_level=1, and saturates at HOLD_CYCLES.
  - btn_hold = (count==HOLD_CYCLES), registered. It asserts once per press and deasserts in the same cycle btn_level falls.
- **Outputs.** All outputs are registered; no combinational path from btn_n.
- **Concurrency.** Simultaneous presses on several channels are processed independently. Their strobes may coincide.

## Timing

- **Reset.** On reset=1, all of the following take effect on the next edge:
  - btn_level=0, btn_press=0, btn_release=0, btn_hold=0;
  - FSM = RELEASED;
  - all counters = 0;
  - synchronizer flops = released.
- **Press latency.** A raw edge that is stable before edge N produces btn_level and btn_press high after edge N+1+DEBOUNCE_CYCLES, i.e. 2 synchronizer cycles plus DEBOUNCE_CYCLES−1 pending cycles plus 1 transition edge.
- **Release latency.** Identical to press latency.
- **Strobe width.** btn_press and btn_release are exactly 1 cycle wide. They are never high in the same cycle for the same channel.
- **Hold latency.** btn_hold rises HOLD_CYCLES+1 cycles after btn_level rises.
- **Reset during a press.** If reset is asserted while a button is held:
  - outputs clear on the next edge;
  - after reset deasserts, the still-held button is re-detected as a new press with full latency, and emits a fresh btn_press.
- **Reset dominance.** Reset asserted in the same cycle a transition would occur: reset wins and no strobe is emitted.
- **Stuck button.** A button held indefinitely leaves btn_level=1 and btn_hold=1. No further strobes are generated and no counter overflows.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=10.

1. **Clean press and release.** Drive btn_n[1] low at cycle 10 and high at cycle 40 → btn_level[1] rises with a single btn_press[1] pulse 6 cycles after the input edge. btn_level[1] falls with a single btn_release[1] pulse 6 cycles after the release edge. Other bits stay 0.
2. **Bounce rejection.** Drive btn_n[0] with a 3-cycle low glitch, 2 cycles high, then a 3-cycle low glitch → all outputs remain 0. Then hold it low for 20 cycles → exactly one btn_press[0], 6 cycles after the final falling edge.
3. **Long press.** Hold btn_n[2] low for 30 cycles → btn_hold[2] rises 11 cycles after btn_level[2] rises and stays high until btn_level[2] falls. Both drop on the same edge, together with btn_release[2].
4. **Simultaneous channels.** Drive btn_n[0] and btn_n[1] low on the same cycle → btn_press[0] and btn_press[1] assert in the same cycle, 6 cycles later.
5. **Reset mid-press.** Hold btn_n[1] low; once btn_level[1]=1, pulse reset for 3 cycles → all outputs 0 on the first reset edge. After reset deasserts with the button still held, a new btn_press[1] appears 6 cycles later and btn_hold[1] restarts from 0.
6. **Reset at power-up.** Drive reset=1 with btn_n=3'b000 → all outputs stay 0 for the entire reset period.
